// File: rtl/neuron_pkg.sv
// Shared constants and FSM encoding for the time-multiplexed neuron scheduler.
package neuron_pkg;
  localparam int N_STAGES         = 6;
  localparam int INPUTS           = 2 ** N_STAGES;
  localparam int OUTPUT_PRECISION = N_STAGES + 2;
  localparam int MINUS_TETA_RESET = -5;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    DONE    = 2'd2
  } sched_state_e;
endpackage

// File: rtl/neuron_state_file.sv
// Per-neuron weights, membrane potential and last-spike flag, with one read port
// (selected neuron) and separate ports for datapath write-back and weight bytes.
module neuron_state_file #(
  parameter int N_NEURONS = 4,
  parameter int INPUTS    = 64,
  parameter int PREC      = 8,
  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int BW = (INPUTS / 8 > 1) ? $clog2(INPUTS / 8) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     i_rd_idx,
  output logic [INPUTS-1:0] o_rd_w,
  output logic [PREC-1:0]   o_rd_u,
  output logic              o_rd_ws,
  input  logic              i_wb_en,
  input  logic [IW-1:0]     i_wb_idx,
  input  logic [PREC-1:0]   i_wb_u,
  input  logic              i_wb_ws,
  input  logic              i_wr_en,
  input  logic [IW-1:0]     i_wr_neuron,
  input  logic [BW-1:0]     i_wr_byte,
  input  logic [7:0]        i_wr_data
);
  logic [INPUTS-1:0] r_w  [N_NEURONS];
  logic [PREC-1:0]   r_u  [N_NEURONS];
  logic              r_ws [N_NEURONS];

  assign o_rd_w  = r_w[i_rd_idx];
  assign o_rd_u  = r_u[i_rd_idx];
  assign o_rd_ws = r_ws[i_rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        r_w[n]  <= '0;
        r_u[n]  <= '0;
        r_ws[n] <= 1'b0;
      end
    end else begin
      if (i_wb_en) begin
        r_u[i_wb_idx]  <= i_wb_u;
        r_ws[i_wb_idx] <= i_wb_ws;
      end
      if (i_wr_en) begin
        r_w[i_wr_neuron][8*i_wr_byte +: 8] <= i_wr_data;
      end
    end
  end
endmodule

// File: rtl/neuron_scheduler.sv
// Collects a spike frame byte-wise, then walks every virtual neuron through the shared
// datapath one per cycle and reports the per-neuron spikes with a one-cycle pulse.
module neuron_scheduler #(
  parameter int  N_STAGES         = neuron_pkg::N_STAGES,
  parameter int  N_NEURONS        = 4,
  localparam int INPUTS           = 2 ** N_STAGES,
  localparam int OUTPUT_PRECISION = N_STAGES + 2,
  localparam int AW               = $clog2(N_NEURONS * INPUTS / 8)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  input  logic                        wcfg_we,
  input  logic [AW-1:0]               wcfg_addr,
  input  logic [7:0]                  wcfg_data,
  output logic                        wcfg_ready,
  input  logic [OUTPUT_PRECISION-1:0] cfg_minus_teta,
  input  logic [2:0]                  cfg_shift,
  output logic [INPUTS-1:0]           dp_x,
  output logic [INPUTS-1:0]           dp_w,
  output logic [2:0]                  dp_shift,
  output logic [OUTPUT_PRECISION-1:0] dp_minus_teta,
  output logic [OUTPUT_PRECISION-1:0] dp_previus_u,
  output logic                        dp_was_spike,
  input  logic [OUTPUT_PRECISION-1:0] dp_u_out,
  input  logic                        dp_is_spike,
  output logic                        spike_valid,
  output logic [N_NEURONS-1:0]        spike_vec,
  output logic                        busy
);
  import neuron_pkg::*;

  localparam int NB = INPUTS / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  sched_state_e                r_state, w_state_nxt;
  logic [BW-1:0]               r_byte_cnt;
  logic [IW-1:0]               r_idx;
  logic [INPUTS-1:0]           r_x;
  logic [OUTPUT_PRECISION-1:0] r_minus_teta;
  logic [2:0]                  r_shift;
  logic [N_NEURONS-1:0]        r_spk, r_spike_vec, w_spk_nxt;
  logic                        w_in_acc, w_last_byte, w_last_idx, w_eval;

  assign in_ready    = (r_state == COLLECT) && !reset;
  assign wcfg_ready  = (r_state != EVAL);
  assign w_eval      = (r_state == EVAL);
  assign w_in_acc    = in_valid && in_ready;
  assign w_last_byte = w_in_acc && (r_byte_cnt == BW'(NB - 1));
  assign w_last_idx  = (r_idx == IW'(N_NEURONS - 1));

  assign dp_x          = r_x;
  assign dp_shift      = r_shift;
  assign dp_minus_teta = r_minus_teta;
  assign spike_vec     = r_spike_vec;

  always_ff @(posedge clk) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    spike_valid = 1'b0;
    unique case (r_state)
      COLLECT: begin
        busy = 1'b0;
        if (w_last_byte) w_state_nxt = EVAL;
      end
      EVAL:    if (w_last_idx) w_state_nxt = DONE;
      DONE: begin
        spike_valid = 1'b1;
        w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    w_spk_nxt        = r_spk;
    w_spk_nxt[r_idx] = dp_is_spike;
  end

  // Threshold and leak are frozen per frame so mid-frame config changes cannot tear a result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt   <= '0;
      r_idx        <= '0;
      r_x          <= '0;
      r_minus_teta <= OUTPUT_PRECISION'(MINUS_TETA_RESET);
      r_shift      <= '0;
      r_spk        <= '0;
      r_spike_vec  <= '0;
    end else begin
      if (w_in_acc) begin
        r_x        <= (r_x << 8) | INPUTS'(in_data);
        r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BW'(1);
        if (w_last_byte) begin
          r_minus_teta <= cfg_minus_teta;
          r_shift      <= cfg_shift;
        end
      end
      if (w_eval) begin
        r_spk <= w_spk_nxt;
        r_idx <= w_last_idx ? '0 : r_idx + IW'(1);
        if (w_last_idx) r_spike_vec <= w_spk_nxt;
      end
    end
  end

  neuron_state_file #(
    .N_NEURONS (N_NEURONS),
    .INPUTS    (INPUTS),
    .PREC      (OUTPUT_PRECISION)
  ) u_state (
    .clk         (clk),
    .reset       (reset),
    .i_rd_idx    (r_idx),
    .o_rd_w      (dp_w),
    .o_rd_u      (dp_previus_u),
    .o_rd_ws     (dp_was_spike),
    .i_wb_en     (w_eval),
    .i_wb_idx    (r_idx),
    .i_wb_u      (dp_u_out),
    .i_wb_ws     (dp_is_spike),
    .i_wr_en     (wcfg_we && wcfg_ready),
    .i_wr_neuron (wcfg_addr[AW-1:BW]),
    .i_wr_byte   (wcfg_addr[BW-1:0]),
    .i_wr_data   (wcfg_data)
  );
endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed and randomized frames against a frame-level model of the scheduler,
// with a stub datapath standing in for the real neuron adder tree.
module tb_neuron_scheduler;
  localparam int N  = 4;
  localparam int IN = 64;
  localparam int P  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wcfg_we;
  logic [4:0]    wcfg_addr;
  logic [7:0]    wcfg_data;
  logic          wcfg_ready;
  logic [P-1:0]  cfg_minus_teta;
  logic [2:0]    cfg_shift;
  logic [IN-1:0] dp_x, dp_w;
  logic [2:0]    dp_shift;
  logic [P-1:0]  dp_minus_teta, dp_previus_u, dp_u_out;
  logic          dp_was_spike, dp_is_spike;
  logic          spike_valid, busy;
  logic [N-1:0]  spike_vec;

  always #5 clk = ~clk;

  neuron_scheduler dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wcfg_we(wcfg_we), .wcfg_addr(wcfg_addr), .wcfg_data(wcfg_data), .wcfg_ready(wcfg_ready),
    .cfg_minus_teta(cfg_minus_teta), .cfg_shift(cfg_shift),
    .dp_x(dp_x), .dp_w(dp_w), .dp_shift(dp_shift), .dp_minus_teta(dp_minus_teta),
    .dp_previus_u(dp_previus_u), .dp_was_spike(dp_was_spike),
    .dp_u_out(dp_u_out), .dp_is_spike(dp_is_spike),
    .spike_valid(spike_valid), .spike_vec(spike_vec), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  bit rand_mode = 1'b0;

  // Model: phase 0 = collecting, 1 = evaluating, 2 = result cycle.
  int           m_phase, m_idx, m_cnt;
  logic [IN-1:0] m_x;
  logic [IN-1:0] m_w [N];
  logic [P-1:0]  m_u [N];
  logic          m_ws [N];
  logic [N-1:0]  m_spk, m_vec;
  logic [P-1:0]  m_teta;
  logic [2:0]    m_shift;
  int            cyc = 0, last_byte_cyc = 0, valid_cyc = -1, pulses = 0;
  logic [N-1:0]  seen_vec;

  function automatic logic [P-1:0] dp_fn(input logic [IN-1:0] x, input logic [IN-1:0] w,
                                         input logic [P-1:0] pu, input logic ws,
                                         input logic [2:0] sh, input logic [P-1:0] mt);
    logic signed [P-1:0] lk;
    lk = $signed(pu) >>> sh;
    return lk + P'($countones(x & w)) + mt - {{(P-1){1'b0}}, ws};
  endfunction

  function automatic logic spike_of(input logic [P-1:0] u);
    return !u[P-1] && (u != '0);
  endfunction

  always_comb begin
    if (rand_mode) dp_u_out = dp_fn(dp_x, dp_w, dp_previus_u, dp_was_spike, dp_shift, dp_minus_teta);
    else           dp_u_out = 8'h10 + 8'(m_idx);
    dp_is_spike = rand_mode ? spike_of(dp_u_out) : (m_idx == 2);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_cnt = 0; m_x = '0;
    for (int n = 0; n < N; n++) begin
      m_w[n] = '0; m_u[n] = '0; m_ws[n] = 1'b0;
    end
    m_spk = '0; m_vec = '0; m_teta = 8'hFB; m_shift = '0;
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance the model after the edge.
  task automatic step(input logic rst, input logic iv, input logic [7:0] d,
                      input logic we, input logic [4:0] wa, input logic [7:0] wd);
    logic [P-1:0] nu;
    logic         ns;
    reset = rst; in_valid = iv; in_data = d;
    wcfg_we = we; wcfg_addr = wa; wcfg_data = wd;
    if (rand_mode) begin
      cfg_minus_teta = 8'($urandom);
      cfg_shift      = 3'($urandom);
    end
    #1;
    check("in_ready",      in_ready,      !rst && m_phase == 0);
    check("busy",          busy,          m_phase != 0);
    check("wcfg_ready",    wcfg_ready,    m_phase != 1);
    check("spike_valid",   spike_valid,   m_phase == 2);
    check("spike_vec",     spike_vec,     m_vec);
    check("dp_x",          dp_x,          m_x);
    check("dp_w",          dp_w,          m_w[m_idx]);
    check("dp_previus_u",  dp_previus_u,  m_u[m_idx]);
    check("dp_was_spike",  dp_was_spike,  m_ws[m_idx]);
    check("dp_minus_teta", dp_minus_teta, m_teta);
    check("dp_shift",      dp_shift,      m_shift);
    if (spike_valid === 1'b1) begin
      valid_cyc = cyc; seen_vec = spike_vec; pulses++;
    end
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      if (we && m_phase != 1) m_w[wa[4:3]][8*wa[2:0] +: 8] = wd;
      case (m_phase)
        0: if (iv) begin
          m_x = {m_x[IN-9:0], d};
          if (m_cnt == 7) begin
            m_cnt = 0; m_teta = cfg_minus_teta; m_shift = cfg_shift;
            m_phase = 1; m_idx = 0; last_byte_cyc = cyc;
          end else m_cnt++;
        end
        1: begin
          if (rand_mode) begin
            nu = dp_fn(m_x, m_w[m_idx], m_u[m_idx], m_ws[m_idx], m_shift, m_teta);
            ns = spike_of(nu);
          end else begin
            nu = 8'h10 + 8'(m_idx);
            ns = (m_idx == 2);
          end
          m_u[m_idx] = nu; m_ws[m_idx] = ns; m_spk[m_idx] = ns;
          if (m_idx == N - 1) begin
            m_phase = 2; m_vec = m_spk; m_idx = 0;
          end else m_idx++;
        end
        default: m_phase = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step_any(input logic iv, input logic [7:0] d);
    if (rand_mode && $urandom_range(0, 2) == 0)
      step(1'b0, iv, d, 1'b1, 5'($urandom), 8'($urandom));
    else
      step(1'b0, iv, d, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic feed(input logic [63:0] fr, input int maxgap);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, maxgap)) step_any(1'b0, 8'($urandom));
      step_any(1'b1, fr[63-8*i -: 8]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step_any(1'b0, 8'($urandom));
  endtask

  initial begin
    int p0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    wcfg_we = 1'b0; wcfg_addr = '0; wcfg_data = '0;
    cfg_minus_teta = 8'h03; cfg_shift = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 8'd0);
    idle(3);

    // Weight byte for neuron 1, then a gapped frame with the counting stub datapath.
    step(1'b0, 1'b0, 8'h00, 1'b1, 5'h0B, 8'hAA);
    cfg_minus_teta = 8'h07; cfg_shift = 3'd3;
    feed(64'h0102030405060708, 2);
    idle(N + 2);
    check("latency_A", valid_cyc - last_byte_cyc, N + 1);
    check("spike_vec_A", seen_vec, 4'b0100);

    // Weight write attempted in the first evaluation cycle must be dropped.
    feed(64'hF0E1D2C3B4A59687, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 5'h00, 8'h55);
    idle(N + 1);
    feed(64'h1122334455667788, 0);
    idle(N + 2);

    // Reset during evaluation of neuron 2 discards the frame.
    feed(64'hDEADBEEFCAFEF00D, 1);
    idle(2);
    p0 = pulses;
    step(1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 8'd0);
    idle(N + 4);
    check("no_pulse_after_reset", pulses - p0, 0);

    rand_mode = 1'b1;
    repeat (25) begin
      valid_cyc = -1;
      feed({$urandom, $urandom}, 2);
      idle($urandom_range(N + 1, N + 4));
      check("latency_rand", valid_cyc - last_byte_cyc, N + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
